// File: rtl/sync_frame_serializer.sv
// Framed serializer: sync byte, PAYLOAD_BYTES payload bytes MSB first, GAP_BITS zeros.
// Latency: frame starts the edge after PAYLOAD_BYTES bytes are buffered; sout registered.
// Backpressure: s_ready drops only while the byte FIFO is full.

module sync_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [7:0]                     push_data,
    input  logic                           pop,
    output logic [7:0]                     head,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;

    assign ready = (count != CW'(DEPTH));
    assign wr_en = push && ready;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module sync_frame_serializer #(
    parameter int         PAYLOAD_BYTES = 4,
    parameter int         FIFO_DEPTH    = 8,
    parameter logic [7:0] SYNC_WORD     = 8'hAB,
    parameter int         GAP_BITS      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       sout,
    output logic       busy,
    output logic       frame_done
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(PAYLOAD_BYTES + 1);
    localparam int GW = $clog2(GAP_BITS + 1);

    typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_t;

    state_t        state, state_nxt;
    logic [2:0]    bit_cnt, bit_nxt, bit_dec;
    logic [BW-1:0] byte_cnt, byte_nxt;
    logic [GW-1:0] gap_cnt, gap_nxt;
    logic [7:0]    sr, sr_nxt;
    logic          sout_nxt;
    logic          busy_nxt;
    logic          frame_done_nxt;
    logic          pop;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic          frame_ready;

    sync_byte_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s_valid),
        .push_data (s_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .ready     (s_ready)
    );

    // Whole payload must be buffered before a frame starts, so DATA never underruns.
    assign frame_ready = (fifo_count >= CW'(PAYLOAD_BYTES));
    assign bit_dec     = bit_cnt - 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            gap_cnt    <= '0;
            sr         <= '0;
            sout       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_nxt;
            byte_cnt   <= byte_nxt;
            gap_cnt    <= gap_nxt;
            sr         <= sr_nxt;
            sout       <= sout_nxt;
            busy       <= busy_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bit_nxt        = bit_cnt;
        byte_nxt       = byte_cnt;
        gap_nxt        = gap_cnt;
        sr_nxt         = sr;
        sout_nxt       = 1'b0;
        frame_done_nxt = 1'b0;
        pop            = 1'b0;

        case (state)
            IDLE: begin
                if (frame_ready) begin
                    state_nxt = SYNC;
                    sout_nxt  = SYNC_WORD[7];
                    bit_nxt   = 3'd7;
                end
            end
            SYNC: begin
                if (bit_cnt != 3'd0) begin
                    bit_nxt  = bit_dec;
                    sout_nxt = SYNC_WORD[bit_dec];
                    // First payload byte is fetched alongside the last sync bit.
                    if (bit_cnt == 3'd1) begin
                        pop      = 1'b1;
                        sr_nxt   = fifo_head;
                        byte_nxt = BW'(1);
                    end
                end else begin
                    state_nxt = DATA;
                    sout_nxt  = sr[7];
                    bit_nxt   = 3'd7;
                end
            end
            DATA: begin
                if (bit_cnt != 3'd0) begin
                    bit_nxt  = bit_dec;
                    sout_nxt = sr[bit_dec];
                end else if (byte_cnt == BW'(PAYLOAD_BYTES)) begin
                    state_nxt      = GAP;
                    frame_done_nxt = 1'b1;
                    gap_nxt        = GW'(1);
                end else begin
                    pop      = 1'b1;
                    sr_nxt   = fifo_head;
                    sout_nxt = fifo_head[7];
                    bit_nxt  = 3'd7;
                    byte_nxt = byte_cnt + BW'(1);
                end
            end
            GAP: begin
                if (gap_cnt != GW'(GAP_BITS)) begin
                    gap_nxt = gap_cnt + GW'(1);
                end else if (frame_ready) begin
                    state_nxt = SYNC;
                    sout_nxt  = SYNC_WORD[7];
                    bit_nxt   = 3'd7;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end
endmodule

// File: tb/tb_sync_frame_serializer.sv
// Bench for sync_frame_serializer: directed scenarios plus random traffic,
// compared cycle by cycle against a frame-position reference model.
module tb_sync_frame_serializer;
    localparam int         P  = 4;
    localparam int         D  = 8;
    localparam int         G  = 8;
    localparam int         FL = 8 + 8 * P + G;
    localparam logic [7:0] SW = 8'hAB;

    logic       clk;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       sout;
    logic       busy;
    logic       frame_done;

    sync_frame_serializer #(
        .PAYLOAD_BYTES (P),
        .FIFO_DEPTH    (D),
        .SYNC_WORD     (SW),
        .GAP_BITS      (G)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .sout       (sout),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: buffered bytes plus position inside the current frame.
    logic [7:0] q [$];
    logic       active;
    int         fpos;
    logic [7:0] fb [P];
    logic [7:0] sw_v;

    // Observation statistics.
    int          busy_cycles;
    int          fd_cnt;
    int          det_pulses;
    logic [7:0]  det_sr;
    logic [39:0] cap;
    int          cap_n;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit();
        int k;
        if (!active) return 1'b0;
        if (fpos < 8) return sw_v[7 - fpos];
        if (fpos < 8 + 8 * P) begin
            k = (fpos - 8) / 8;
            return fb[k][7 - ((fpos - 8) % 8)];
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        active = 1'b0;
        fpos   = 0;
    endtask

    task automatic model_step(input logic vld, input logic [7:0] d);
        logic rdy;
        rdy = (q.size() != D);
        if (active) begin
            fpos++;
            if (fpos == FL) active = 1'b0;
        end
        if (!active && q.size() >= P) begin
            active = 1'b1;
            fpos   = 0;
            for (int k = 0; k < P; k++) fb[k] = q[k];
        end
        if (active && (fpos == 7 || (fpos >= 16 && fpos < 8 + 8 * P && (fpos - 8) % 8 == 0)))
            void'(q.pop_front());
        if (vld && rdy) q.push_back(d);
    endtask

    task automatic clear_stats();
        busy_cycles = 0;
        fd_cnt      = 0;
        det_pulses  = 0;
        det_sr      = '0;
        cap         = '0;
        cap_n       = 0;
    endtask

    // One clock: drive at negedge, step model at posedge, compare at next negedge.
    task automatic cycle(input logic vld, input logic [7:0] d);
        s_valid = vld;
        s_data  = d;
        check("s_ready", s_ready, (q.size() != D));
        @(posedge clk);
        model_step(vld, d);
        @(negedge clk);
        check("sout", sout, exp_bit());
        check("busy", busy, active);
        check("frame_done", frame_done, active && fpos == 8 + 8 * P);
        if (busy) busy_cycles++;
        if (frame_done) fd_cnt++;
        if (busy && cap_n < 40) begin
            cap = {cap[38:0], sout};
            cap_n++;
        end
        det_sr = {det_sr[6:0], sout};
        if (det_sr == sw_v) det_pulses++;
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        #1;
        check("rst_sout", sout, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_s_ready", s_ready, 1'b1);
        check("rst_count", dut.fifo_count, 0);
        model_reset();
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] cur;
        int         n_acc;
        logic       saw_full;
        logic       reached;
        logic [39:0] exp_frame;

        sw_v    = SW;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        model_reset();
        clear_stats();

        // Reset held for 3 cycles, then 100 idle cycles with a quiet line.
        @(negedge clk);
        do_reset(3);
        idle(100);
        check("idle_busy_cycles", busy_cycles, 0);

        // Single frame 12 34 56 78.
        clear_stats();
        cycle(1'b1, 8'h12);
        cycle(1'b1, 8'h34);
        cycle(1'b1, 8'h56);
        cycle(1'b1, 8'h78);
        idle(60);
        exp_frame = 40'hAB_12_34_56_78;
        check("frame_bits", cap, exp_frame);
        check("frame_done_count", fd_cnt, 1);
        check("busy_cycles", busy_cycles, FL);

        // Three bytes never start a frame; the fourth does within two cycles.
        clear_stats();
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom));
        idle(50);
        check("no_frame_3_bytes", busy_cycles, 0);
        cycle(1'b1, 8'($urandom));
        cycle(1'b0, 8'h00);
        check("sync_start_sout", sout, 1'b1);
        check("sync_start_busy", busy, 1'b1);
        idle(FL);

        // Nine bytes with s_valid held: FIFO fills, ninth accepted after a pop.
        do_reset(2);
        clear_stats();
        n_acc    = 0;
        saw_full = 1'b0;
        cur      = 8'($urandom);
        for (int t = 0; t < 100 && n_acc < 9; t++) begin
            if (!s_ready) saw_full = 1'b1;
            b = cur;
            if (s_ready) begin
                n_acc++;
                cur = 8'($urandom);
            end
            cycle(1'b1, b);
        end
        check("accepted_9", n_acc, 9);
        check("saw_full", saw_full, 1'b1);
        idle(2 * FL + 10);
        check("two_frames_fd", fd_cnt, 2);
        check("leftover_count", dut.fifo_count, 1);

        // Eight zero bytes: back-to-back frames, detector sees exactly two syncs.
        do_reset(2);
        clear_stats();
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'h00);
        idle(2 * FL + 20);
        check("detector_pulses", det_pulses, 2);
        check("zero_frames_fd", fd_cnt, 2);
        check("zero_frames_busy", busy_cycles, 2 * FL);

        // Reset on the 5th DATA bit aborts the frame and flushes the FIFO.
        do_reset(2);
        clear_stats();
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom));
        reached = 1'b0;
        for (int t = 0; t < 40 && !reached; t++) begin
            if (active && fpos == 12) reached = 1'b1;
            else cycle(1'b0, 8'h00);
        end
        check("reached_data_bit5", reached, 1'b1);
        do_reset(2);
        check("abort_no_frame_done", fd_cnt, 0);
        clear_stats();
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom));
        idle(30);
        check("abort_no_restart", busy_cycles, 0);
        cycle(1'b1, 8'($urandom));
        idle(FL + 5);
        check("abort_then_frame", fd_cnt, 1);

        // Random traffic at three offered loads.
        for (int seg = 0; seg < 3; seg++) begin
            cur = 8'($urandom);
            for (int t = 0; t < 1000; t++) begin
                if ($urandom_range(0, 3) < seg + 1) begin
                    b = cur;
                    if (s_ready) cur = 8'($urandom);
                    cycle(1'b1, b);
                end else begin
                    cycle(1'b0, 8'h00);
                end
            end
        end
        idle(3 * FL);
        check("random_drain_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
